// File: rtl/spi_burst_ctrl.sv
// -----------------------------------------------------------------------------
// spi_burst_ctrl
//   Burst sequencer placed directly in front of an SPI master byte engine.
//   The host queues bytes in a TX FIFO and pulses i_start. The block then
//   lowers chip select once, hands the queued bytes to the master one at a
//   time over the transmit_data/transfer/ready handshake, and stores every
//   received byte in an RX FIFO. Chip select stays low from the setup phase
//   through the hold phase, with no deassertion between bytes.
//
// Ports
//   i_clk                 system clock
//   i_rst_n               asynchronous reset, active low (shared with master)
//   i_wr_en / i_wr_data   push a byte into the TX FIFO (ignored when full)
//   o_tx_full             TX FIFO full
//   o_tx_count            TX FIFO occupancy, 0..DEPTH
//   i_rd_en               pop the RX FIFO head (ignored when empty)
//   o_rd_data             RX FIFO head, first-word fall-through
//   o_rx_empty            RX FIFO empty
//   o_rx_overflow         sticky: a received byte was dropped (RX full)
//   i_start               begin a burst (sampled only in IDLE)
//   o_busy                high in every state except IDLE
//   o_done                one-cycle pulse at the end of a burst
//   o_cs_n                chip select, active low
//   o_spi_transmit_data   byte for the master
//   o_spi_transfer        one-cycle transfer request to the master
//   i_spi_ready           master ready
//   i_spi_received_data   byte returned by the master
// -----------------------------------------------------------------------------

// Small FIFO with a registered first-word-fall-through head. Storage is a
// plain array (no reset on the contents); only pointers, count and the head
// register are reset. On a simultaneous push and pop the pop is taken first,
// so a push into a full FIFO succeeds when it is also being popped.
module spi_burst_fifo #(
  parameter int DL    = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_push,
  input  logic [DL-1:0] i_data,
  input  logic          i_pop,
  output logic [DL-1:0] o_head,
  output logic [AW:0]   o_count
);

  logic [DL-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [DL-1:0] r_head;

  logic          w_full;
  logic          w_empty;
  logic          w_pop_ok;
  logic          w_push_ok;
  logic [AW-1:0] w_rd_ptr_next;
  logic [AW:0]   w_count_next;

  always_comb begin
    w_full        = (r_count == (AW+1)'(DEPTH));
    w_empty       = (r_count == '0);
    w_pop_ok      = i_pop && !w_empty;
    w_push_ok     = i_push && (!w_full || w_pop_ok);
    w_rd_ptr_next = r_rd_ptr + AW'(w_pop_ok);
    w_count_next  = r_count + {{AW{1'b0}}, w_push_ok} - {{AW{1'b0}}, w_pop_ok};
  end

  always_ff @(posedge i_clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_head   <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      r_rd_ptr <= w_rd_ptr_next;
      r_count  <= w_count_next;
      // Preload the next head. When the slot being written this cycle is the
      // new head (FIFO was empty after the pop), bypass the array.
      // When the FIFO drains, the head keeps its last value.
      if (w_count_next != '0) begin
        if (w_push_ok && (r_wr_ptr == w_rd_ptr_next)) begin
          r_head <= i_data;
        end else begin
          r_head <= r_mem[w_rd_ptr_next];
        end
      end
    end
  end

  assign o_head  = r_head;
  assign o_count = r_count;

endmodule

module spi_burst_ctrl #(
  parameter int DL       = 8,
  parameter int DEPTH    = 16,
  parameter int AW       = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_wr_en,
  input  logic [DL-1:0] i_wr_data,
  output logic          o_tx_full,
  output logic [AW:0]   o_tx_count,
  input  logic          i_rd_en,
  output logic [DL-1:0] o_rd_data,
  output logic          o_rx_empty,
  output logic          o_rx_overflow,
  input  logic          i_start,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_cs_n,
  output logic [DL-1:0] o_spi_transmit_data,
  output logic          o_spi_transfer,
  input  logic          i_spi_ready,
  input  logic [DL-1:0] i_spi_received_data
);

  localparam int CNT_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] SETUP_LAST = CW'(CS_SETUP - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(CS_HOLD - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_LOAD,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_STORE,
    S_HOLD,
    S_DONE
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;

  logic          r_cs_n;
  logic          r_busy;
  logic          r_done;
  logic          r_spi_transfer;
  logic [DL-1:0] r_spi_tx_data;
  logic [DL-1:0] r_rx_byte;
  logic          r_rx_overflow;

  logic          w_tx_pop;
  logic          w_rx_push;
  logic          w_empty_start;
  logic          w_start_seen;
  logic [DL-1:0] w_tx_head;
  logic [AW:0]   w_tx_count;
  logic [AW:0]   w_rx_count;
  logic          w_tx_empty;
  logic          w_rx_full;

  spi_burst_fifo #(.DL(DL), .DEPTH(DEPTH), .AW(AW)) u_tx_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (i_wr_en),
    .i_data  (i_wr_data),
    .i_pop   (w_tx_pop),
    .o_head  (w_tx_head),
    .o_count (w_tx_count)
  );

  spi_burst_fifo #(.DL(DL), .DEPTH(DEPTH), .AW(AW)) u_rx_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_rx_push),
    .i_data  (r_rx_byte),
    .i_pop   (i_rd_en),
    .o_head  (o_rd_data),
    .o_count (w_rx_count)
  );

  assign w_tx_empty = (w_tx_count == '0);
  assign w_rx_full  = (w_rx_count == (AW+1)'(DEPTH));

  // Next-state and per-cycle controls.
  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt;
    w_tx_pop      = 1'b0;
    w_rx_push     = 1'b0;
    w_empty_start = 1'b0;
    w_start_seen  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_start_seen = 1'b1;
          if (!w_tx_empty) begin
            w_state_next = S_SETUP;
            w_cnt_next   = '0;
          end else begin
            w_empty_start = 1'b1;
          end
        end
      end
      S_SETUP: begin
        if (r_cnt == SETUP_LAST) begin
          w_state_next = S_LOAD;
        end else begin
          w_cnt_next = r_cnt + CW'(1);
        end
      end
      S_LOAD: begin
        if (i_spi_ready) begin
          w_tx_pop     = 1'b1;
          w_state_next = S_WAIT_BUSY;
        end
      end
      S_WAIT_BUSY: begin
        if (!i_spi_ready) begin
          w_state_next = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (i_spi_ready) begin
          w_state_next = S_STORE;
        end
      end
      S_STORE: begin
        w_rx_push = 1'b1;
        // A host push landing in this very cycle still extends the burst;
        // the TX FIFO cannot be full when it is empty, so that push is taken.
        if (!w_tx_empty || i_wr_en) begin
          w_state_next = S_LOAD;
        end else begin
          w_state_next = S_HOLD;
          w_cnt_next   = '0;
        end
      end
      S_HOLD: begin
        if (r_cnt == HOLD_LAST) begin
          w_state_next = S_DONE;
        end else begin
          w_cnt_next = r_cnt + CW'(1);
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they change together with
  // the state register and never glitch.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_cs_n         <= 1'b1;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_spi_transfer <= 1'b0;
      r_spi_tx_data  <= '0;
      r_rx_byte      <= '0;
      r_rx_overflow  <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_cnt          <= w_cnt_next;
      r_cs_n         <= (w_state_next == S_IDLE) || (w_state_next == S_DONE);
      r_busy         <= (w_state_next != S_IDLE);
      r_done         <= (w_state_next == S_DONE) || w_empty_start;
      r_spi_transfer <= w_tx_pop;
      if (w_tx_pop) begin
        r_spi_tx_data <= w_tx_head;
      end
      // Received data is only guaranteed on the first ready-high cycle.
      if ((r_state == S_WAIT_DONE) && i_spi_ready) begin
        r_rx_byte <= i_spi_received_data;
      end
      // A same-cycle host pop frees a slot before the store, so no drop.
      if (w_start_seen) begin
        r_rx_overflow <= 1'b0;
      end else if (w_rx_push && w_rx_full && !i_rd_en) begin
        r_rx_overflow <= 1'b1;
      end
    end
  end

  assign o_tx_full           = (w_tx_count == (AW+1)'(DEPTH));
  assign o_tx_count          = w_tx_count;
  assign o_rx_empty          = (w_rx_count == '0);
  assign o_rx_overflow       = r_rx_overflow;
  assign o_busy              = r_busy;
  assign o_done              = r_done;
  assign o_cs_n              = r_cs_n;
  assign o_spi_transmit_data = r_spi_tx_data;
  assign o_spi_transfer      = r_spi_transfer;

endmodule
